// File: rtl/swd_dp_target.sv
// SWD Debug Port target: oversamples SWCLK/SWDIO, decodes line reset, the JTAG-to-SWD select
// sequence and request/ACK/data phases, holds the DP registers and forwards AP accesses.
module swd_dp_target #(
    parameter logic [31:0] IDCODE      = 32'h2BA01477,
    parameter int          SYNC_STAGES = 2,
    parameter int          WTRN_EDGES  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        swclk_i,
    input  logic        swdio_i,
    output logic        swdio_o,
    output logic        swdio_oe_o,
    output logic        cdbgpwrup_o,
    output logic        csyspwrup_o,
    output logic        ap_req_o,
    output logic        ap_wr_o,
    output logic [7:0]  ap_addr_o,
    output logic [31:0] ap_wdata_o,
    input  logic        ap_ack_i,
    input  logic [31:0] ap_rdata_i
);
    typedef enum logic [3:0] {
        ST_DORMANT, ST_LR1, ST_ARMED, ST_RESET, ST_IDLE, ST_REQ,
        ST_ACK, ST_RDATA, ST_WTRN, ST_WDATA, ST_TURN
    } state_t;

    localparam logic [5:0] WTRN_LAST = 6'(WTRN_EDGES - 2);

    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] swclk_sync_q, swdio_sync_q;
    logic        swclk_prev_q;
    logic [5:0]  ones_q, ones_d, ones_inc;
    logic [15:0] sel_sr_q, sel_sr_d;
    logic [6:0]  hdr_q, hdr_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        wait_q, wait_d;
    logic [31:0] sh_q, sh_d;
    logic        par_q, par_d;
    logic        swdio_q, swdio_d, oe_q, oe_d;
    logic        cdbg_q, cdbg_d, csys_q, csys_d;
    logic        proterr_q, proterr_d, wdataerr_q, wdataerr_d;
    logic [3:0]  apbank_q, apbank_d;
    logic [31:0] rdbuff_q, rdbuff_d;
    logic        ap_req_q, ap_req_d, ap_wr_q, ap_wr_d;
    logic [7:0]  ap_addr_q, ap_addr_d;
    logic [31:0] ap_wdata_q, ap_wdata_d;
    logic        swclk_rise, swdio_s, line_rst;
    logic [31:0] ctrl_stat, dp_rdata;

    assign swclk_rise = swclk_sync_q[SYNC_STAGES-1] & ~swclk_prev_q;
    assign swdio_s    = swdio_sync_q[SYNC_STAGES-1];

    // Power-up ACK bits mirror the request bits: there is no power controller behind this DP.
    assign ctrl_stat = {csys_q, csys_q, cdbg_q, cdbg_q, 20'b0, wdataerr_q, 5'b0, proterr_q, 1'b0};

    always_comb begin
        case (hdr_q[3:2])
            2'b00:   dp_rdata = IDCODE;
            2'b01:   dp_rdata = ctrl_stat;
            2'b11:   dp_rdata = rdbuff_q;
            default: dp_rdata = 32'h0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ones_d     = ones_q;
        sel_sr_d   = sel_sr_q;
        hdr_d      = hdr_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        sh_d       = sh_q;
        par_d      = par_q;
        swdio_d    = swdio_q;
        oe_d       = oe_q;
        cdbg_d     = cdbg_q;
        csys_d     = csys_q;
        proterr_d  = proterr_q;
        wdataerr_d = wdataerr_q;
        apbank_d   = apbank_q;
        rdbuff_d   = rdbuff_q;
        ap_req_d   = ap_req_q;
        ap_wr_d    = ap_wr_q;
        ap_addr_d  = ap_addr_q;
        ap_wdata_d = ap_wdata_q;
        ones_inc   = (ones_q == 6'd63) ? ones_q : ones_q + 6'd1;
        line_rst   = 1'b0;

        // AP completion is applied before any SWD edge in the same cycle, so the ACK sees it.
        if (ap_ack_i && ap_req_q) begin
            ap_req_d = 1'b0;
            if (!ap_wr_q) rdbuff_d = ap_rdata_i;
        end

        if (swclk_rise) begin
            ones_d   = swdio_s ? ones_inc : 6'd0;
            line_rst = swdio_s && (ones_inc >= 6'd50);
            if (line_rst && state_q != ST_DORMANT && state_q != ST_LR1) begin
                state_d = ST_RESET;
                oe_d    = 1'b0;
                swdio_d = 1'b0;
            end else begin
                case (state_q)
                    ST_DORMANT: if (line_rst) state_d = ST_LR1;
                    ST_LR1: begin
                        sel_sr_d = {swdio_s, sel_sr_q[15:1]};
                        if (sel_sr_d == 16'hE79E) state_d = ST_ARMED;
                    end
                    ST_ARMED: begin end
                    ST_RESET: if (!swdio_s) state_d = ST_IDLE;
                    ST_IDLE: begin
                        if (swdio_s) begin
                            state_d = ST_REQ;
                            cnt_d   = 6'd0;
                        end
                    end
                    ST_REQ: begin
                        hdr_d = {swdio_s, hdr_q[6:1]};
                        cnt_d = cnt_q + 6'd1;
                        if (cnt_q == 6'd6) begin
                            cnt_d = 6'd0;
                            if ((^hdr_d[4:0]) || hdr_d[5] || !hdr_d[6]) begin
                                proterr_d = 1'b1;
                                state_d   = ST_IDLE;
                            end else begin
                                state_d = ST_ACK;
                            end
                        end
                    end
                    ST_ACK: begin
                        oe_d  = 1'b1;
                        cnt_d = cnt_q + 6'd1;
                        if (cnt_q == 6'd0) begin
                            wait_d  = ap_req_d && (hdr_q[0] || (hdr_q[1] && hdr_q[3:2] == 2'b11));
                            swdio_d = !wait_d;
                        end else if (cnt_q == 6'd1) begin
                            swdio_d = wait_q;
                        end else begin
                            swdio_d = 1'b0;
                            cnt_d   = 6'd0;
                            if (wait_q) begin
                                state_d = ST_TURN;
                            end else if (hdr_q[1]) begin
                                state_d = ST_RDATA;
                                if (hdr_q[0]) begin
                                    // Posted read: hand back the previous result, launch the next.
                                    sh_d      = rdbuff_q;
                                    ap_req_d  = 1'b1;
                                    ap_wr_d   = 1'b0;
                                    ap_addr_d = {apbank_q, hdr_q[3:2], 2'b00};
                                end else begin
                                    sh_d = dp_rdata;
                                end
                                par_d = ^sh_d;
                            end else begin
                                state_d = (WTRN_EDGES <= 1) ? ST_WDATA : ST_WTRN;
                            end
                        end
                    end
                    ST_RDATA: begin
                        cnt_d = cnt_q + 6'd1;
                        if (cnt_q < 6'd32) begin
                            swdio_d = sh_q[0];
                            sh_d    = {1'b0, sh_q[31:1]};
                        end else if (cnt_q == 6'd32) begin
                            swdio_d = par_q;
                        end else begin
                            swdio_d = 1'b0;
                            oe_d    = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end
                    ST_WTRN: begin
                        oe_d    = 1'b0;
                        swdio_d = 1'b0;
                        cnt_d   = cnt_q + 6'd1;
                        if (cnt_q == WTRN_LAST) begin
                            cnt_d   = 6'd0;
                            state_d = ST_WDATA;
                        end
                    end
                    ST_WDATA: begin
                        oe_d    = 1'b0;
                        swdio_d = 1'b0;
                        cnt_d   = cnt_q + 6'd1;
                        if (cnt_q < 6'd32) begin
                            sh_d = {swdio_s, sh_q[31:1]};
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = 6'd0;
                            if (swdio_s != ^sh_q) begin
                                wdataerr_d = 1'b1;
                            end else if (hdr_q[0]) begin
                                ap_req_d   = 1'b1;
                                ap_wr_d    = 1'b1;
                                ap_addr_d  = {apbank_q, hdr_q[3:2], 2'b00};
                                ap_wdata_d = sh_q;
                            end else begin
                                case (hdr_q[3:2])
                                    2'b00: begin
                                        if (sh_q[0]) ap_req_d   = 1'b0;
                                        if (sh_q[2]) proterr_d  = 1'b0;
                                        if (sh_q[3]) wdataerr_d = 1'b0;
                                    end
                                    2'b01: begin
                                        cdbg_d = sh_q[28];
                                        csys_d = sh_q[30];
                                    end
                                    2'b10:   apbank_d = sh_q[7:4];
                                    default: begin end
                                endcase
                            end
                        end
                    end
                    ST_TURN: begin
                        oe_d    = 1'b0;
                        swdio_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                    default: state_d = ST_DORMANT;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_DORMANT;
            swclk_sync_q <= '0;
            swdio_sync_q <= '0;
            swclk_prev_q <= 1'b0;
            ones_q       <= 6'd0;
            sel_sr_q     <= 16'h0;
            hdr_q        <= 7'h0;
            cnt_q        <= 6'd0;
            wait_q       <= 1'b0;
            sh_q         <= 32'h0;
            par_q        <= 1'b0;
            swdio_q      <= 1'b0;
            oe_q         <= 1'b0;
            cdbg_q       <= 1'b0;
            csys_q       <= 1'b0;
            proterr_q    <= 1'b0;
            wdataerr_q   <= 1'b0;
            apbank_q     <= 4'h0;
            rdbuff_q     <= 32'h0;
            ap_req_q     <= 1'b0;
            ap_wr_q      <= 1'b0;
            ap_addr_q    <= 8'h0;
            ap_wdata_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            swclk_sync_q <= {swclk_sync_q[SYNC_STAGES-2:0], swclk_i};
            swdio_sync_q <= {swdio_sync_q[SYNC_STAGES-2:0], swdio_i};
            swclk_prev_q <= swclk_sync_q[SYNC_STAGES-1];
            ones_q       <= ones_d;
            sel_sr_q     <= sel_sr_d;
            hdr_q        <= hdr_d;
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            sh_q         <= sh_d;
            par_q        <= par_d;
            swdio_q      <= swdio_d;
            oe_q         <= oe_d;
            cdbg_q       <= cdbg_d;
            csys_q       <= csys_d;
            proterr_q    <= proterr_d;
            wdataerr_q   <= wdataerr_d;
            apbank_q     <= apbank_d;
            rdbuff_q     <= rdbuff_d;
            ap_req_q     <= ap_req_d;
            ap_wr_q      <= ap_wr_d;
            ap_addr_q    <= ap_addr_d;
            ap_wdata_q   <= ap_wdata_d;
        end
    end

    assign swdio_o     = swdio_q;
    assign swdio_oe_o  = oe_q;
    assign cdbgpwrup_o = cdbg_q;
    assign csyspwrup_o = csys_q;
    assign ap_req_o    = ap_req_q;
    assign ap_wr_o     = ap_wr_q;
    assign ap_addr_o   = ap_addr_q;
    assign ap_wdata_o  = ap_wdata_q;
endmodule
